// File: rtl/uart_pkg.sv
// Shared UART types and constants for the RX path and the WB UART slave.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned lp_UART_DW      = 8;
    localparam int unsigned lp_DEF_BAUD_DIV = 868;
    localparam int unsigned lp_BAUD_CW      = 16;

    // Status register bit positions, shared with the WB slave.
    localparam int unsigned lp_STS_BUSY_BIT = 0;
    localparam int unsigned lp_STS_EF_BIT   = 1;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered empty/full/count/head.
// AW must be at least 1.
module uart_sync_fifo #(
    parameter int unsigned AW = 4,
    parameter int unsigned DW = 8
) (
    input  logic          i_clk,
    input  logic          i_srst_n,
    input  logic          i_wr,
    input  logic [DW-1:0] iv_wdata,
    input  logic          i_rd,
    output logic          o_ef,
    output logic          o_ff,
    output logic [AW:0]   ov_cnt,
    output logic [DW-1:0] ov_rdata,
    output logic          o_wr_drop_c
);

    localparam int unsigned lp_DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [lp_DEPTH];
    logic [AW:0]   r_wp;
    logic [AW:0]   r_rp;
    logic [AW:0]   r_cnt;
    logic          r_ef;
    logic          r_ff;
    logic [DW-1:0] r_head;

    logic          w_pop;
    logic          w_push;
    logic [AW:0]   w_wp_nxt;
    logic [AW:0]   w_rp_nxt;
    logic          w_ef_nxt;
    logic          w_ff_nxt;
    logic [DW-1:0] w_head_nxt;

    // Accept/pop qualification and next-state view of pointers and head word.
    always_comb begin
        w_pop       = i_rd & ~r_ef;
        w_push      = i_wr & (~r_ff | w_pop);
        o_wr_drop_c = i_wr & ~w_push;
        w_wp_nxt    = r_wp + (AW+1)'(w_push);
        w_rp_nxt    = r_rp + (AW+1)'(w_pop);
        w_ef_nxt    = (w_wp_nxt == w_rp_nxt);
        w_ff_nxt    = (w_wp_nxt[AW] != w_rp_nxt[AW]) &&
                      (w_wp_nxt[AW-1:0] == w_rp_nxt[AW-1:0]);
        w_head_nxt  = r_head;
        if (!w_ef_nxt) begin
            // The new head is the word being written when it lands in the head slot.
            if (w_push && (w_rp_nxt[AW-1:0] == r_wp[AW-1:0])) begin
                w_head_nxt = iv_wdata;
            end else begin
                w_head_nxt = r_mem[w_rp_nxt[AW-1:0]];
            end
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= iv_wdata;
        end
    end

    // Pointers plus registered flags, count and head word.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_ef   <= 1'b1;
            r_ff   <= 1'b0;
            r_head <= '0;
        end else begin
            r_wp   <= w_wp_nxt;
            r_rp   <= w_rp_nxt;
            r_cnt  <= w_wp_nxt - w_rp_nxt;
            r_ef   <= w_ef_nxt;
            r_ff   <= w_ff_nxt;
            r_head <= w_head_nxt;
        end
    end

    assign o_ef     = r_ef;
    assign o_ff     = r_ff;
    assign ov_cnt   = r_cnt;
    assign ov_rdata = r_head;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a FWFT receive FIFO, with framing/overflow status.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV    = lp_DEF_BAUD_DIV,
    parameter int unsigned FIFO_AW     = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_srst_n,
    input  logic                  i_uart_rx,
    input  logic                  i_rfifo_rd,
    output logic                  o_rfifo_ef,
    output logic [7:0]            ov_rfifo_data,
    output logic                  o_rfifo_ff,
    output logic [FIFO_AW:0]      ov_rfifo_cnt,
    output logic                  o_frame_err,
    output logic                  o_ovf_err,
    input  logic                  i_err_clr,
    output logic                  o_rx_busy
);

    localparam int unsigned lp_HALF  = BAUD_DIV / 2 - 1;
    localparam int unsigned lp_FULL  = BAUD_DIV - 1;
    localparam int unsigned lp_BIT_W = $clog2(lp_UART_DW);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_rx_d;
    uart_state_t            r_state;
    logic [lp_BAUD_CW-1:0]  r_baud;
    logic [lp_BIT_W-1:0]    r_bit;
    logic [lp_UART_DW-1:0]  r_shift;
    logic                   r_frame_err;
    logic                   r_busy;
    logic                   r_ovf;

    logic                   w_rx_s;
    logic                   w_fall;
    logic                   w_cnt_zero;
    logic                   w_push;
    logic                   w_drop;

    assign w_rx_s     = r_sync[SYNC_STAGES-1];
    assign w_fall     = r_rx_d & ~w_rx_s;
    assign w_cnt_zero = (r_baud == '0);
    assign w_push     = (r_state == STOP) & w_cnt_zero & w_rx_s;

    // Metastability synchronizer and edge-detect history; idle line is high.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_sync <= '1;
            r_rx_d <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_uart_rx};
            r_rx_d <= w_rx_s;
        end
    end

    // Receive FSM with baud counter; samples at counter zero, mid-bit.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_state     <= IDLE;
            r_baud      <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_baud  <= lp_BAUD_CW'(lp_HALF);
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_cnt_zero) begin
                        if (!w_rx_s) begin
                            r_bit   <= '0;
                            r_baud  <= lp_BAUD_CW'(lp_FULL);
                            r_state <= DATA;
                        end else begin
                            // Start bit did not hold to mid-bit: treat as a glitch.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_baud <= r_baud - lp_BAUD_CW'(1);
                    end
                end
                DATA: begin
                    if (w_cnt_zero) begin
                        r_shift <= {w_rx_s, r_shift[lp_UART_DW-1:1]};
                        r_baud  <= lp_BAUD_CW'(lp_FULL);
                        if (r_bit == lp_BIT_W'(lp_UART_DW - 1)) begin
                            r_state <= STOP;
                        end else begin
                            r_bit <= r_bit + lp_BIT_W'(1);
                        end
                    end else begin
                        r_baud <= r_baud - lp_BAUD_CW'(1);
                    end
                end
                STOP: begin
                    if (w_cnt_zero) begin
                        r_frame_err <= ~w_rx_s;
                        r_state     <= IDLE;
                        r_busy      <= 1'b0;
                    end else begin
                        r_baud <= r_baud - lp_BAUD_CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky overflow flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (i_err_clr) begin
            r_ovf <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .AW (FIFO_AW),
        .DW (lp_UART_DW)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_srst_n    (i_srst_n),
        .i_wr        (w_push),
        .iv_wdata    (r_shift),
        .i_rd        (i_rfifo_rd),
        .o_ef        (o_rfifo_ef),
        .o_ff        (o_rfifo_ff),
        .ov_cnt      (ov_rfifo_cnt),
        .ov_rdata    (ov_rfifo_data),
        .o_wr_drop_c (w_drop)
    );

    assign o_frame_err = r_frame_err;
    assign o_ovf_err   = r_ovf;
    assign o_rx_busy   = r_busy;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo at BAUD_DIV=16, FIFO_AW=2.
module tb_uart_rx_fifo;

    localparam int unsigned BD    = 16;
    localparam int unsigned AW    = 2;
    localparam int unsigned SS    = 2;
    localparam int unsigned DEPTH = 4;

    logic          clk;
    logic          srst_n;
    logic          uart_rx;
    logic          rfifo_rd;
    logic          rfifo_ef;
    logic [7:0]    rfifo_data;
    logic          rfifo_ff;
    logic [AW:0]   rfifo_cnt;
    logic          frame_err;
    logic          ovf_err;
    logic          err_clr;
    logic          rx_busy;

    uart_rx_fifo #(
        .BAUD_DIV    (BD),
        .FIFO_AW     (AW),
        .SYNC_STAGES (SS)
    ) dut (
        .i_clk         (clk),
        .i_srst_n      (srst_n),
        .i_uart_rx     (uart_rx),
        .i_rfifo_rd    (rfifo_rd),
        .o_rfifo_ef    (rfifo_ef),
        .ov_rfifo_data (rfifo_data),
        .o_rfifo_ff    (rfifo_ff),
        .ov_rfifo_cnt  (rfifo_cnt),
        .o_frame_err   (frame_err),
        .o_ovf_err     (ovf_err),
        .i_err_clr     (err_clr),
        .o_rx_busy     (rx_busy)
    );

    int errors;
    int checks;
    int cyc;
    int start_cyc;
    int fe_total;
    int busy_total;
    int ef_fall_cyc;
    logic prev_ef;
    logic exp_ovf;
    logic [7:0] exp_q [$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_total++;
        if (rx_busy === 1'b1) busy_total++;
        if (prev_ef === 1'b1 && rfifo_ef === 1'b0) ef_fall_cyc = cyc;
        prev_ef = rfifo_ef;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Expected-value model: word enters the scoreboard unless the model FIFO is full.
    task automatic push_exp(input logic [7:0] d);
        if (exp_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovf = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        @(posedge clk); #1;
        uart_rx   = 1'b0;
        start_cyc = cyc;
        for (int b = 0; b < 8; b++) begin
            repeat (BD) @(posedge clk); #1;
            uart_rx = d[b];
        end
        repeat (BD) @(posedge clk); #1;
        uart_rx = stop_b;
        repeat (BD) @(posedge clk); #1;
        uart_rx = 1'b1;
    endtask

    task automatic read_word(input string name);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, DUT ef=%b data=%h", name, rfifo_ef, rfifo_data);
        end else begin
            e = exp_q.pop_front();
            if (rfifo_ef !== 1'b0 || rfifo_data !== e) begin
                errors++;
                $display("FAIL %s: got ef=%b data=%h, want ef=0 data=%h", name, rfifo_ef, rfifo_data, e);
            end
        end
        rfifo_rd = 1'b1;
        wait_cyc(1);
        rfifo_rd = 1'b0;
    endtask

    task automatic check_cnt(input string name);
        checks++;
        if (rfifo_cnt !== (AW+1)'(exp_q.size()) || rfifo_ff !== (exp_q.size() == DEPTH)) begin
            errors++;
            $display("FAIL %s: got cnt=%0d ff=%b, want cnt=%0d ff=%b", name, rfifo_cnt, rfifo_ff,
                     exp_q.size(), (exp_q.size() == DEPTH));
        end
    endtask

    task automatic check_reset_outs(input string name);
        checks++;
        if (rfifo_ef !== 1'b1 || rfifo_ff !== 1'b0 || rfifo_cnt !== '0 || rfifo_data !== 8'h00 ||
            frame_err !== 1'b0 || ovf_err !== 1'b0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got ef=%b ff=%b cnt=%0d data=%h fe=%b ovf=%b busy=%b, want 1 0 0 00 0 0 0",
                     name, rfifo_ef, rfifo_ff, rfifo_cnt, rfifo_data, frame_err, ovf_err, rx_busy);
        end
    endtask

    task automatic test_reset();
        srst_n   = 1'b0;
        uart_rx  = 1'b1;
        rfifo_rd = 1'b0;
        err_clr  = 1'b0;
        wait_cyc(3);
        check_reset_outs("reset");
        srst_n = 1'b1;
        wait_cyc(2);
    endtask

    task automatic test_basic();
        push_exp(8'hA5);
        send_frame(8'hA5, 1'b1);
        wait_cyc(4);
        checks++;
        if (ef_fall_cyc !== start_cyc + 155) begin
            errors++;
            $display("FAIL basic_ef_latency: ef fell at offset %0d, want 155", ef_fall_cyc - start_cyc);
        end
        check_cnt("basic_cnt");
        read_word("basic_data");
        check_cnt("basic_after_read");
        checks++;
        if (rfifo_ef !== 1'b1) begin
            errors++;
            $display("FAIL basic_ef_after_read: got %b want 1", rfifo_ef);
        end
    endtask

    task automatic test_glitch();
        int b0;
        int f0;
        b0 = busy_total;
        f0 = fe_total;
        @(posedge clk); #1;
        uart_rx = 1'b0;
        wait_cyc(4);
        uart_rx = 1'b1;
        wait_cyc(40);
        checks++;
        if ((busy_total - b0) < 1 || (busy_total - b0) > 8 + SS) begin
            errors++;
            $display("FAIL glitch_busy: busy cycles=%0d, want 1..%0d", busy_total - b0, 8 + SS);
        end
        checks++;
        if (fe_total != f0 || rx_busy !== 1'b0) begin
            errors++;
            $display("FAIL glitch_state: frame_err cycles=%0d busy=%b, want 0 and 0", fe_total - f0, rx_busy);
        end
        check_cnt("glitch_cnt");
    endtask

    task automatic test_frame_err();
        int f0;
        f0 = fe_total;
        send_frame(8'h3C, 1'b0);
        wait_cyc(4);
        checks++;
        if (fe_total - f0 != 1) begin
            errors++;
            $display("FAIL frame_err_pulse: high cycles=%0d want 1", fe_total - f0);
        end
        check_cnt("frame_err_cnt");
        push_exp(8'h55);
        send_frame(8'h55, 1'b1);
        wait_cyc(4);
        check_cnt("frame_next_cnt");
        read_word("frame_next_data");
    endtask

    task automatic test_overflow();
        exp_ovf = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            push_exp(8'(i));
            send_frame(8'(i), 1'b1);
            wait_cyc(4);
            check_cnt($sformatf("ovf_fill_%0d", i));
            checks++;
            if (ovf_err !== exp_ovf) begin
                errors++;
                $display("FAIL ovf_flag_%0d: got %b want %b", i, ovf_err, exp_ovf);
            end
        end
        wait_cyc(20);
        for (int i = 1; i <= 4; i++) read_word($sformatf("ovf_read_%0d", i));
        checks++;
        if (ovf_err !== 1'b1 || rfifo_ef !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b ef=%b want 1 1", ovf_err, rfifo_ef);
        end
        err_clr = 1'b1;
        wait_cyc(1);
        err_clr = 1'b0;
        exp_ovf = 1'b0;
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b want 0", ovf_err);
        end
    endtask

    task automatic test_simul_push_pop();
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            push_exp(fill[i]);
            send_frame(fill[i], 1'b1);
            wait_cyc(4);
        end
        check_cnt("simul_full");
        fork
            send_frame(8'h77, 1'b1);
            begin
                @(posedge clk);
                repeat (154) @(posedge clk);
                #1;
                read_word("simul_pop_head");
                exp_q.push_back(8'h77);
            end
        join
        wait_cyc(4);
        checks++;
        if (ovf_err !== 1'b0) begin
            errors++;
            $display("FAIL simul_ovf: got %b want 0", ovf_err);
        end
        check_cnt("simul_cnt");
        for (int i = 0; i < 4; i++) read_word($sformatf("simul_read_%0d", i));
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        uart_rx = 1'b0;
        wait_cyc(BD * 4 + 4);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy_before_reset: got %b want 1", rx_busy);
        end
        srst_n  = 1'b0;
        uart_rx = 1'b1;
        wait_cyc(3);
        check_reset_outs("mid_reset_outs");
        srst_n = 1'b1;
        wait_cyc(30);
        check_reset_outs("mid_after_release");
        push_exp(8'h0F);
        send_frame(8'h0F, 1'b1);
        wait_cyc(4);
        check_cnt("mid_next_cnt");
        read_word("mid_next_data");
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        exp_ovf  = 1'b0;
        srst_n   = 1'b0;
        uart_rx  = 1'b1;
        rfifo_rd = 1'b0;
        err_clr  = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_simul_push_pop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Serial UART receiver (8N1, LSB first) with a first-word-fall-through receive FIFO.
- Sits directly upstream of the WB UART slave's RX path.
- Supplies that slave's rfifo empty flag and rfifo data inputs, and consumes its rfifo read strobe.
- Also reports framing and overflow errors for status/interrupt use.

Parameters:
- BAUD_DIV, 868, clocks per bit (100 MHz / 115200); legal range 8..65535.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW entries.
- SYNC_STAGES, 2, flip-flop stages on i_uart_rx; minimum 2.

Ports:
- i_clk  in  1  system clock, single domain.
- i_srst_n  in  1  synchronous reset, active low.
- i_uart_rx  in  1  asynchronous serial input; idle high.
- i_rfifo_rd  in  1  pop strobe, one cycle per word (connects to the slave's o_ctrl_rfifo_rd).
- o_rfifo_ef  out  1  FIFO empty (connects to the slave's i_sts_rfifo_ef).
- ov_rfifo_data  out  8  FIFO head word, FWFT (connects to the slave's iv_sts_rfifo_data).
- o_rfifo_ff  out  1  FIFO full.
- ov_rfifo_cnt  out  FIFO_AW+1  occupancy, 0..2**FIFO_AW.
- o_frame_err  out  1  one-cycle pulse when a bad stop bit is detected.
- o_ovf_err  out  1  sticky: a byte was dropped because the FIFO was full.
- i_err_clr  in  1  clears o_ovf_err.
- o_rx_busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (i_srst_n=0 at a clock edge):
  - FSM goes to IDLE; bit counter and baud counter clear; FIFO pointers clear.
  - Outputs: o_rfifo_ef=1, o_rfifo_ff=0, ov_rfifo_cnt=0, ov_rfifo_data=0, o_frame_err=0, o_ovf_err=0, o_rx_busy=0.
  - Synchronizer flops reset to 1 (idle line).
  - Reset mid-frame aborts the frame; no partial byte is written.
- Input conditioning: i_uart_rx passes through SYNC_STAGES flops. All decisions use the synchronized value rx_s.
- FSM states:
  - IDLE: on a falling edge of rx_s, load baud counter with BAUD_DIV/2-1 and go to START.
  - START: at counter zero, sample rx_s.
    - 0: bit index=0, counter=BAUD_DIV-1, go to DATA.
    - 1: glitch; go to IDLE with no error.
  - DATA: at each counter zero, shift rx_s into shift[7] (shift right, LSB first) and reload the counter.
    - After the 8th sample, go to STOP.
  - STOP: at counter zero, sample rx_s.
    - 1: push the byte.
    - 0: pulse o_frame_err for 1 cycle and discard the byte.
    - Either way, go to IDLE. The next start bit may be detected from the following cycle.
- Timing: every sample point is mid-bit, (BAUD_DIV/2)+k*BAUD_DIV cycles after the synchronized falling edge. The push happens 9.5 bit times after that edge.
- Push rules:
  - Push is accepted when the FIFO is not full, or when i_rfifo_rd pops in the same cycle.
  - Otherwise the byte is dropped and o_ovf_err is set.
  - If i_err_clr and a new overflow occur in the same cycle, the set wins.
- FIFO (FWFT):
  - ov_rfifo_data always shows the head word. Its value is don't-care while empty, but the bench expects it to hold the last value.
  - A pushed word becomes visible, with o_rfifo_ef=0, on the cycle after the push edge (1-cycle latency).
  - i_rfifo_rd while empty is ignored: pointers unchanged, no error.
  - Simultaneous push and pop with a non-empty FIFO leaves the count unchanged.
  - Simultaneous push and pop with an empty FIFO: the pop is ignored and the push proceeds.
  - Pointers are FIFO_AW+1 bits and wrap naturally.
  - ef = (wp==rp). ff = MSBs differ and the lower bits are equal.
  - cnt = wp-rp, modulo 2**(FIFO_AW+1).
- o_rx_busy = (state != IDLE), registered.

Decomposition:
- Package uart_pkg holds:
  - the state enum {IDLE, START, DATA, STOP};
  - lp_UART_DW=8 and lp_DEF_BAUD_DIV=868;
  - the status bit-index constants (busy=0, ef=1) shared with the WB slave.
- One sub-module: uart_sync_fifo (parameter AW, DW=8; FWFT, ef/ff/cnt). It is reusable by a future TX FIFO.
- Synchronizer, FSM and baud counter stay in the top module.

Test Plan:
- All tests use BAUD_DIV=16, FIFO_AW=2, and bit period 16 clocks.
- Basic receive: send 0xA5, then read once.
  - Required: o_rfifo_ef falls 1 cycle after the push; ov_rfifo_data=0xA5; cnt=1.
  - After i_rfifo_rd: ef=1, cnt=0.
- Glitch rejection: a 4-clock low pulse on an idle line.
  - Required: return to IDLE; no push; o_frame_err never asserts; o_rx_busy high for at most 8+SYNC_STAGES cycles.
- Framing error: send 0x3C with stop bit=0.
  - Required: a single-cycle o_frame_err; cnt stays 0.
  - A following valid 0x55 is received correctly.
- Overflow and wrap: send 0x01..0x05 with no reads.
  - Required: ff=1 after 0x04; 0x05 dropped; o_ovf_err=1 and stays 1.
  - Reads return 0x01..0x04 in order.
  - i_err_clr clears o_ovf_err.
- Simultaneous push/pop at full: with the FIFO full, assert i_rfifo_rd in the exact push cycle of 0x77.
  - Required: o_ovf_err stays 0; cnt stays 4; 0x77 becomes the last word read.
- Reset mid-frame: deassert i_srst_n during DATA bit 3 of 0xF0, then release.
  - Required: all outputs at reset values; no byte in the FIFO.
  - The next frame, 0x0F, is received correctly.
